// File: rtl/mux_select_scanner_if.sv
// Signal bundle between board control, the bit scanner and the 7-to-1 mux.
// master is the board/mux side; slave is the scanner.
interface mux_select_scanner_if;
  logic       start;
  logic       mux_bit;
  logic [2:0] mux_sel;
  logic       busy;
  logic       done;
  logic       bit_valid;
  logic       serial_out;
  logic [6:0] word_out;

  modport master (
    output start, mux_bit,
    input  mux_sel, busy, done, bit_valid, serial_out, word_out
  );

  modport slave (
    input  start, mux_bit,
    output mux_sel, busy, done, bit_valid, serial_out, word_out
  );
endinterface

// File: rtl/mux_select_scanner.sv
// Steps a 7-to-1 mux select through 0..NUM_BITS-1, dwelling TICK_CYCLES clocks
// per position, and assembles the sampled mux output into a parallel word.
module mux_select_scanner #(
  parameter int NUM_BITS    = 7,
  parameter int TICK_CYCLES = 4,
  parameter int CNT_W       = 26
) (
  input  logic                 clock,
  input  logic                 reset,
  mux_select_scanner_if.slave  bus
);

  localparam int               WORD_W   = 7;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_CYCLES - 1);
  localparam logic [2:0]       LAST_SEL = 3'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [2:0]          sel_reg;
  logic [WORD_W-1:0]   capture_reg;
  logic [WORD_W-1:0]   capture_next;
  logic [WORD_W-1:0]   word_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                valid_reg;
  logic                serial_reg;
  logic                sample_hit;
  logic                last_pos;

  assign sample_hit = (cnt_reg == LAST_CNT);
  assign last_pos   = (sel_reg == LAST_SEL);

  // Capture image with the current position already overwritten, so the final
  // sample lands in word_out on the same edge it is taken. Unscanned bits stay 0.
  generate
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_cap
      if (gi < NUM_BITS) begin : g_live
        assign capture_next[gi] = (sel_reg == 3'(gi)) ? bus.mux_bit : capture_reg[gi];
      end else begin : g_dead
        assign capture_next[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      sel_reg     <= '0;
      capture_reg <= '0;
      word_reg    <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      serial_reg  <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          sel_reg <= '0;
          cnt_reg <= '0;
          if (bus.start) begin
            state_reg   <= SCAN;
            busy_reg    <= 1'b1;
            capture_reg <= '0;
          end
        end
        SCAN: begin
          if (sample_hit) begin
            cnt_reg     <= '0;
            capture_reg <= capture_next;
            serial_reg  <= bus.mux_bit;
            valid_reg   <= 1'b1;
            if (last_pos) begin
              word_reg  <= capture_next;
              sel_reg   <= '0;
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              sel_reg <= sel_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          // start is deliberately ignored here; it is only honoured from IDLE
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mux_sel    = sel_reg;
  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.bit_valid  = valid_reg;
  assign bus.serial_out = serial_reg;
  assign bus.word_out   = word_reg;

endmodule

// File: tb/tb_mux_select_scanner.sv
// Drives three scanner configurations from one stimulus stream and checks every
// output each cycle against a timeline model derived from the scan start edge.
module tb_mux_select_scanner;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_all;
  logic [7:0] sw;      // bit 7 stands in for the mux default branch (reads 0)
  logic       noise;   // corrupts mux_bit to prove only the sample-edge value counts

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mux_select_scanner_if if_a ();
  mux_select_scanner_if if_b ();
  mux_select_scanner_if if_c ();

  mux_select_scanner #(.NUM_BITS(7), .TICK_CYCLES(4), .CNT_W(26)) u_a (
    .clock(clock), .reset(reset), .bus(if_a.slave));
  mux_select_scanner #(.NUM_BITS(7), .TICK_CYCLES(1), .CNT_W(26)) u_b (
    .clock(clock), .reset(reset), .bus(if_b.slave));
  mux_select_scanner #(.NUM_BITS(3), .TICK_CYCLES(4), .CNT_W(26)) u_c (
    .clock(clock), .reset(reset), .bus(if_c.slave));

  assign if_a.start = start_all;
  assign if_b.start = start_all;
  assign if_c.start = start_all;
  assign if_a.mux_bit = sw[if_a.mux_sel] ^ noise;
  assign if_b.mux_bit = sw[if_b.mux_sel] ^ noise;
  assign if_c.mux_bit = sw[if_c.mux_sel] ^ noise;

  logic [2:0] sel_o[3];
  logic       busy_o[3];
  logic       done_o[3];
  logic       valid_o[3];
  logic       ser_o[3];
  logic [6:0] word_o[3];

  assign sel_o[0] = if_a.mux_sel;   assign sel_o[1] = if_b.mux_sel;   assign sel_o[2] = if_c.mux_sel;
  assign busy_o[0] = if_a.busy;     assign busy_o[1] = if_b.busy;     assign busy_o[2] = if_c.busy;
  assign done_o[0] = if_a.done;     assign done_o[1] = if_b.done;     assign done_o[2] = if_c.done;
  assign valid_o[0] = if_a.bit_valid; assign valid_o[1] = if_b.bit_valid; assign valid_o[2] = if_c.bit_valid;
  assign ser_o[0] = if_a.serial_out; assign ser_o[1] = if_b.serial_out; assign ser_o[2] = if_c.serial_out;
  assign word_o[0] = if_a.word_out; assign word_o[1] = if_b.word_out; assign word_o[2] = if_c.word_out;

  // Reference model: each instance is either idle or t edges past its start edge.
  int         nb[3] = '{7, 7, 3};
  int         tc[3] = '{4, 1, 4};
  string      nm[3] = '{"a", "b", "c"};
  bit         act[3];
  int         tt[3];
  logic [6:0] cap[3];
  logic [6:0] wrd[3];
  logic       ser[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input logic r, input logic s,
                            input logic [7:0] w, input logic n);
    int   sel_m;
    int   p;
    logic b;
    if (r) begin
      act[i] = 1'b0; tt[i] = 0; cap[i] = '0; wrd[i] = '0; ser[i] = 1'b0;
      return;
    end
    if (act[i]) begin
      sel_m = (tt[i] < nb[i] * tc[i]) ? tt[i] / tc[i] : 0;
      b = w[sel_m] ^ n;
      tt[i]++;
      if (tt[i] > nb[i] * tc[i]) begin
        act[i] = 1'b0;
      end else if (tt[i] % tc[i] == 0) begin
        p = tt[i] / tc[i] - 1;
        cap[i][p] = b;
        ser[i] = b;
        if (p == nb[i] - 1) begin
          wrd[i] = cap[i];
          $display("scan %s complete: word=%02h", nm[i], wrd[i]);
        end
      end
    end else if (s) begin
      act[i] = 1'b1; tt[i] = 0; cap[i] = '0;
    end
  endtask

  task automatic compare_all();
    int  full;
    bit  scanning;
    for (int i = 0; i < 3; i++) begin
      full     = nb[i] * tc[i];
      scanning = act[i] && (tt[i] < full);
      check($sformatf("%s.busy", nm[i]), 32'(busy_o[i]), 32'(scanning));
      check($sformatf("%s.done", nm[i]), 32'(done_o[i]), 32'(act[i] && tt[i] == full));
      check($sformatf("%s.mux_sel", nm[i]), 32'(sel_o[i]), scanning ? 32'(tt[i] / tc[i]) : 32'd0);
      check($sformatf("%s.bit_valid", nm[i]), 32'(valid_o[i]),
            32'(act[i] && tt[i] > 0 && (tt[i] % tc[i] == 0)));
      check($sformatf("%s.serial_out", nm[i]), 32'(ser_o[i]), 32'(ser[i]));
      check($sformatf("%s.word_out", nm[i]), 32'(word_o[i]), 32'(wrd[i]));
    end
  endtask

  task automatic tick(input logic r, input logic s, input logic [6:0] w, input logic n);
    reset = r; start_all = s; sw = {1'b0, w}; noise = n;
    for (int i = 0; i < 3; i++) model_step(i, r, s, {1'b0, w}, n);
    @(negedge clock);
    compare_all();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      act[i] = 1'b0; tt[i] = 0; cap[i] = '0; wrd[i] = '0; ser[i] = 1'b0;
    end

    // reset held with start high
    tick(1'b1, 1'b1, 7'h00, 1'b0);
    tick(1'b1, 1'b1, 7'h00, 1'b0);
    check("reset.word", 32'(word_o[0]), 32'h0);
    check("reset.busy", 32'(busy_o[0]), 32'h0);
    repeat (3) tick(1'b0, 1'b0, 7'h00, 1'b0);
    check("idle.done", 32'(done_o[0]), 32'h0);

    // basic scan of 7'b1010011
    tick(1'b0, 1'b1, 7'h53, 1'b0);
    repeat (34) tick(1'b0, 1'b0, 7'h53, 1'b0);
    check("basic.word_a", 32'(word_o[0]), 32'h53);
    check("basic.word_b", 32'(word_o[1]), 32'h53);
    check("basic.word_c", 32'(word_o[2]), 32'h03);

    // second start pulse ten edges into a scan
    tick(1'b0, 1'b1, 7'h53, 1'b0);
    repeat (9) tick(1'b0, 1'b0, 7'h53, 1'b0);
    tick(1'b0, 1'b1, 7'h53, 1'b0);
    repeat (24) tick(1'b0, 1'b0, 7'h53, 1'b0);
    check("busy_start.word_a", 32'(word_o[0]), 32'h53);

    // start held continuously: back-to-back scans
    repeat (70) tick(1'b0, 1'b1, 7'h53, 1'b0);
    repeat (35) tick(1'b0, 1'b0, 7'h53, 1'b0);

    // reset at E12 of a scan of 7'h7F
    tick(1'b0, 1'b1, 7'h7F, 1'b0);
    repeat (11) tick(1'b0, 1'b0, 7'h7F, 1'b0);
    tick(1'b1, 1'b0, 7'h7F, 1'b0);
    check("midrst.word_a", 32'(word_o[0]), 32'h0);
    check("midrst.busy_a", 32'(busy_o[0]), 32'h0);
    tick(1'b0, 1'b1, 7'h7F, 1'b0);
    repeat (34) tick(1'b0, 1'b0, 7'h7F, 1'b0);
    check("rescan.word_a", 32'(word_o[0]), 32'h7F);
    check("rescan.word_c", 32'(word_o[2]), 32'h07);

    // glitch on mux_bit mid-dwell of position 3, quiet at its sample edge
    tick(1'b0, 1'b1, 7'h77, 1'b0);
    for (int j = 1; j <= 34; j++) tick(1'b0, 1'b0, 7'h77, (j == 13 || j == 14));
    check("glitch.word_a", 32'(word_o[0]), 32'h77);

    // randomized traffic
    repeat (1500)
      tick(($urandom % 250) == 0, ($urandom % 6) == 0, 7'($urandom), ($urandom % 4) == 0);
    repeat (40) tick(1'b0, 1'b0, 7'h2A, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
